serdes_link_ctrl: RTL and testbench
===================================

SERDES_LINK_CTRL -- requirements
Module: serdes_link_ctrl

Interface
REQ-001 SHALL take parameter CLKS_PER_BIT, default 4, giving clock cycles per serial bit period; legal range 2..255.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port tx_valid, input, 1, transmit request; the parallel word is already presented to the serializer.
REQ-005 SHALL have port tx_ready, output, 1, high when a new transmit request is accepted.
REQ-006 SHALL have port load_en, output, 1, one-cycle strobe that loads the serializer parallel register (drives serdes par_en).
REQ-007 SHALL have port shift_en, output, 1, one-cycle strobe that advances the serializer by one bit (drives serdes ser_en).
REQ-008 SHALL have port tx_done, output, 1, one-cycle pulse at the end of a transmitted word.
REQ-009 SHALL have port rx_line, input, 1, raw serial line monitored for framing, idle high.
REQ-010 SHALL have port sample_en, output, 1, one-cycle strobe that shifts one bit into the deserializer.
REQ-011 SHALL have port cap_en, output, 1, one-cycle strobe that latches the deserialized word to data_out (drives serdes data_en).
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-013 SHALL have port rx_busy, output, 1, high whenever the RX FSM is not in R_IDLE.

Function
REQ-014 SHALL run independent TX and RX state machines concurrently, with no shared counters.
REQ-015 SHALL implement the TX FSM with states T_IDLE, T_LOAD and T_SHIFT, plus a divider counter and a 4-bit bit counter.
REQ-016 SHALL drive tx_ready=1 only in T_IDLE.
REQ-017 SHALL transition T_IDLE->T_LOAD on tx_valid&tx_ready (cycle N).
REQ-018 SHALL assert load_en for exactly cycle N+1 (T_LOAD), then go to T_SHIFT.
REQ-019 SHALL, in T_SHIFT, pulse shift_en at cycles N+1+k*CLKS_PER_BIT for k=1..8, giving exactly 8 pulses.
REQ-020 SHALL assert tx_done together with the 8th shift_en, return to T_IDLE the next cycle, and raise tx_ready at N+2+8*CLKS_PER_BIT.
REQ-021 SHALL ignore tx_valid outside T_IDLE, with no queuing; tx_valid held high continuously gives back-to-back words with 1 idle cycle between them.
REQ-022 SHALL pass rx_line through a 2-flop synchronizer (reset value 1) before use, with all RX timing referenced to the synchronized signal rxs.
REQ-023 SHALL implement the RX FSM with states R_IDLE, R_START, R_DATA and R_STOP.
REQ-024 SHALL transition R_IDLE->R_START on rxs==0.
REQ-025 SHALL, in R_START, wait CLKS_PER_BIT/2 (integer floor) cycles, then go to R_DATA if rxs==0, else return to R_IDLE as a glitch, with no strobes.
REQ-026 SHALL, in R_DATA, pulse sample_en every CLKS_PER_BIT cycles, 8 pulses total, the first one CLKS_PER_BIT cycles after leaving R_START, then go to R_STOP.
REQ-027 SHALL, in R_STOP, after CLKS_PER_BIT cycles sample rxs: if 1, pulse cap_en; if 0, pulse frame_err and do not pulse cap_en; in either case return to R_IDLE the next cycle.
REQ-028 SHALL allow a new start bit to be detected on the first cycle back in R_IDLE.
REQ-029 SHALL never assert cap_en and frame_err in the same cycle, and never assert load_en and shift_en in the same cycle.
REQ-030 SHALL count divider and bit counters up from 0, resetting them on every state entry, with no wrap beyond 8 bits.

Reset
REQ-031 SHALL, on rst_n low, immediately force T_IDLE and R_IDLE, clear all counters, set the synchronizer flops to 1, and drive load_en, shift_en, tx_done, sample_en, cap_en, frame_err and rx_busy to 0 and tx_ready to 1.
REQ-032 SHALL abandon a word in progress when reset occurs mid-word, emitting no further strobes.
REQ-033 SHALL accept tx_valid on the first clock edge after rst_n deasserts.

Verification (CLKS_PER_BIT=4)
REQ-034 SHALL cover a single TX word: tx_valid at cycle 10 -> load_en at 11; shift_en at 15,19,...,43; tx_done at 43; tx_ready back at 44.
REQ-035 SHALL cover an RX frame: rx_line low for 4 cycles, then 8 data bits, then high stop -> exactly 8 sample_en spaced 4 apart, then one cap_en, frame_err=0.
REQ-036 SHALL cover a bad stop bit: same frame with stop held 0 -> frame_err pulse, no cap_en, rx_busy falls the next cycle.
REQ-037 SHALL cover a start glitch: rx_line low for 1 cycle -> return to R_IDLE, zero sample_en pulses.
REQ-038 SHALL cover reset mid-operation: rst_n low during the 4th shift_en period and an RX data phase -> all strobes 0, tx_ready=1, rx_busy=0 immediately; a fresh tx_valid after release gives the REQ-034 timing.
REQ-039 SHALL cover concurrent TX and RX activity: a TX word and an RX frame overlapping -> both timings identical to the standalone cases.

Source files
------------

// File: rtl/serdes_link_ctrl.sv
// Link controller for a serializer/deserializer pair: a TX FSM produces load/shift
// strobes for an 8-bit word; an independent RX FSM frames a start/8-data/stop line.
module serdes_link_ctrl #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tx_valid,
  output logic tx_ready,
  output logic load_en,
  output logic shift_en,
  output logic tx_done,
  input  logic rx_line,
  output logic sample_en,
  output logic cap_en,
  output logic frame_err,
  output logic rx_busy
);

  localparam logic [7:0] DIV_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0] BIT_LAST  = 4'd7;

  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_LOAD  = 2'd1;
  localparam logic [1:0] T_SHIFT = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  logic [1:0] r_tx_state;
  logic [7:0] r_tx_div;
  logic [3:0] r_tx_bits;
  logic       w_tx_tick;

  logic [1:0] r_rx_state;
  logic [7:0] r_rx_div;
  logic [3:0] r_rx_bits;
  logic [1:0] r_sync;
  logic       w_rxs;
  logic       w_rx_tick;

  // NOTE: strobes are decoded straight from registered state with continuous
  // assigns, so they cannot latch and drop to 0 the instant reset asserts.
  assign w_tx_tick = (r_tx_state == T_SHIFT) && (r_tx_div == DIV_LAST);
  assign tx_ready  = (r_tx_state == T_IDLE);
  assign load_en   = (r_tx_state == T_LOAD);
  assign shift_en  = w_tx_tick;
  assign tx_done   = w_tx_tick && (r_tx_bits == BIT_LAST);

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= T_IDLE;
      r_tx_div   <= '0;
      r_tx_bits  <= '0;
    end else begin
      case (r_tx_state)
        T_IDLE: begin
          r_tx_div  <= '0;
          r_tx_bits <= '0;
          if (tx_valid) r_tx_state <= T_LOAD;
        end
        T_LOAD: begin
          r_tx_div   <= '0;
          r_tx_bits  <= '0;
          r_tx_state <= T_SHIFT;
        end
        T_SHIFT: begin
          if (w_tx_tick) begin
            r_tx_div <= '0;
            if (r_tx_bits == BIT_LAST) begin
              r_tx_bits  <= '0;
              r_tx_state <= T_IDLE;
            end else begin
              r_tx_bits <= r_tx_bits + 4'd1;
            end
          end else begin
            r_tx_div <= r_tx_div + 8'd1;
          end
        end
        default: r_tx_state <= T_IDLE;
      endcase
    end
  end

  // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], rx_line};
  end

  assign w_rxs     = r_sync[1];
  assign w_rx_tick = (r_rx_div == DIV_LAST);
  assign sample_en = (r_rx_state == R_DATA) && w_rx_tick;
  assign cap_en    = (r_rx_state == R_STOP) && w_rx_tick && w_rxs;
  assign frame_err = (r_rx_state == R_STOP) && w_rx_tick && !w_rxs;
  assign rx_busy   = (r_rx_state != R_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= R_IDLE;
      r_rx_div   <= '0;
      r_rx_bits  <= '0;
    end else begin
      case (r_rx_state)
        R_IDLE: begin
          r_rx_div  <= '0;
          r_rx_bits <= '0;
          if (!w_rxs) r_rx_state <= R_START;
        end
        R_START: begin
          // Re-check the line half a bit in; a high line here was only a glitch.
          if (r_rx_div == HALF_LAST) begin
            r_rx_div   <= '0;
            r_rx_state <= w_rxs ? R_IDLE : R_DATA;
          end else begin
            r_rx_div <= r_rx_div + 8'd1;
          end
        end
        R_DATA: begin
          if (w_rx_tick) begin
            r_rx_div <= '0;
            if (r_rx_bits == BIT_LAST) begin
              r_rx_bits  <= '0;
              r_rx_state <= R_STOP;
            end else begin
              r_rx_bits <= r_rx_bits + 4'd1;
            end
          end else begin
            r_rx_div <= r_rx_div + 8'd1;
          end
        end
        R_STOP: begin
          if (w_rx_tick) begin
            r_rx_div   <= '0;
            r_rx_state <= R_IDLE;
          end else begin
            r_rx_div <= r_rx_div + 8'd1;
          end
        end
        default: r_rx_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_link_ctrl.sv
// Directed bench for serdes_link_ctrl (CLKS_PER_BIT=4): strobe timestamps are logged
// per cycle and compared against hand-derived cycle numbers.
module tb_serdes_link_ctrl;

  localparam int CPB = 4;
  localparam int EV_LOAD = 0, EV_SHIFT = 1, EV_DONE = 2, EV_SAMP = 3, EV_CAP = 4, EV_FERR = 5;

  logic clk = 1'b0;
  logic rst_n, tx_valid, rx_line;
  logic tx_ready, load_en, shift_en, tx_done, sample_en, cap_en, frame_err, rx_busy;

  int cyc = 0;
  int ev_t [6][64];
  int ev_n [6];
  int n_checks = 0;
  int n_errors = 0;

  serdes_link_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .load_en(load_en),
    .shift_en(shift_en), .tx_done(tx_done),
    .rx_line(rx_line), .sample_en(sample_en), .cap_en(cap_en),
    .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void rec(int k);
    if (ev_n[k] < 64) begin
      ev_t[k][ev_n[k]] = cyc;
      ev_n[k]++;
    end
  endfunction

  int n_overlap = 0;
  always @(negedge clk) begin
    if (load_en)   rec(EV_LOAD);
    if (shift_en)  rec(EV_SHIFT);
    if (tx_done)   rec(EV_DONE);
    if (sample_en) rec(EV_SAMP);
    if (cap_en)    rec(EV_CAP);
    if (frame_err) rec(EV_FERR);
    if ((load_en && shift_en) || (cap_en && frame_err)) n_overlap++;
  end

  function automatic void clear_ev();
    for (int k = 0; k < 6; k++) begin
      ev_n[k] = 0;
      ev_t[k][0] = -1;
    end
  endfunction

  function automatic bit seq_ok(int k, int first, int step, int n);
    if (ev_n[k] != n) return 1'b0;
    for (int i = 0; i < n; i++)
      if (ev_t[k][i] != first + i * step) return 1'b0;
    return 1'b1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Start bit, 8 data bits (LSB first), stop bit; each held CPB cycles.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_line = bits[b];
      repeat (CPB) next_cycle();
    end
    rx_line = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst_n = 1'b0; tx_valid = 1'b0; rx_line = 1'b1;
    #1;
    got = {tx_ready, load_en, shift_en, tx_done, sample_en, cap_en, frame_err, rx_busy};
    n_checks++;
    if (got !== 8'b1000_0000) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b want 10000000", got);
    end
    repeat (3) next_cycle();
    got = {tx_ready, load_en, shift_en, tx_done, sample_en, cap_en, frame_err, rx_busy};
    n_checks++;
    if (got !== 8'b1000_0000) begin
      n_errors++;
      $display("FAIL reset_held: got %b want 10000000", got);
    end
    rst_n = 1'b1;
    next_cycle();
    n_checks++;
    if (tx_ready !== 1'b1 || rx_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: tx_ready=%b rx_busy=%b want 1 0", tx_ready, rx_busy);
    end
  endtask

  task automatic test_tx_single();
    int t;
    clear_ev();
    t = cyc;
    tx_valid = 1'b1;
    next_cycle();
    tx_valid = 1'b0;
    wait_cyc(t + 33);
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL tx_ready_busy: got %b want 0 at cycle %0d", tx_ready, cyc);
    end
    wait_cyc(t + 34);
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL tx_ready_back: got %b want 1 at cycle %0d", tx_ready, cyc);
    end
    wait_cyc(t + 40);
    n_checks++;
    if (seq_ok(EV_LOAD, t + 1, 0, 1) !== 1'b1) begin
      n_errors++;
      $display("FAIL tx_load: %0d pulses first@%0d, want 1 at %0d", ev_n[EV_LOAD], ev_t[EV_LOAD][0], t + 1);
    end
    n_checks++;
    if (seq_ok(EV_SHIFT, t + 1 + CPB, CPB, 8) !== 1'b1) begin
      n_errors++;
      $display("FAIL tx_shift: %0d pulses first@%0d, want 8 from %0d step %0d", ev_n[EV_SHIFT], ev_t[EV_SHIFT][0], t + 1 + CPB, CPB);
    end
    n_checks++;
    if (seq_ok(EV_DONE, t + 1 + 8 * CPB, 0, 1) !== 1'b1) begin
      n_errors++;
      $display("FAIL tx_done: %0d pulses first@%0d, want 1 at %0d", ev_n[EV_DONE], ev_t[EV_DONE][0], t + 1 + 8 * CPB);
    end
  endtask

  task automatic test_rx_frame(input logic stop_bit);
    int r;
    clear_ev();
    r = cyc;
    send_frame(8'hA5, stop_bit);
    wait_cyc(r + 40);
    n_checks++;
    if (rx_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL rx_busy_stop(stop=%b): got %b want 1", stop_bit, rx_busy);
    end
    wait_cyc(r + 41);
    n_checks++;
    if (rx_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rx_busy_fall(stop=%b): got %b want 0", stop_bit, rx_busy);
    end
    wait_cyc(r + 50);
    n_checks++;
    if (seq_ok(EV_SAMP, r + 8, CPB, 8) !== 1'b1) begin
      n_errors++;
      $display("FAIL rx_sample(stop=%b): %0d pulses first@%0d, want 8 from %0d", stop_bit, ev_n[EV_SAMP], ev_t[EV_SAMP][0], r + 8);
    end
    n_checks++;
    if (seq_ok(EV_CAP, r + 40, 0, stop_bit ? 1 : 0) !== 1'b1) begin
      n_errors++;
      $display("FAIL rx_cap(stop=%b): %0d pulses first@%0d, want %0d at %0d", stop_bit, ev_n[EV_CAP], ev_t[EV_CAP][0], stop_bit ? 1 : 0, r + 40);
    end
    n_checks++;
    if (seq_ok(EV_FERR, r + 40, 0, stop_bit ? 0 : 1) !== 1'b1) begin
      n_errors++;
      $display("FAIL rx_ferr(stop=%b): %0d pulses first@%0d, want %0d at %0d", stop_bit, ev_n[EV_FERR], ev_t[EV_FERR][0], stop_bit ? 0 : 1, r + 40);
    end
  endtask

  task automatic test_glitch();
    int r;
    clear_ev();
    r = cyc;
    rx_line = 1'b0;
    next_cycle();
    rx_line = 1'b1;
    wait_cyc(r + 3);
    n_checks++;
    if (rx_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL glitch_start: rx_busy=%b want 1", rx_busy);
    end
    wait_cyc(r + 5);
    n_checks++;
    if (rx_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL glitch_idle: rx_busy=%b want 0", rx_busy);
    end
    wait_cyc(r + 20);
    n_checks++;
    if (ev_n[EV_SAMP] + ev_n[EV_CAP] + ev_n[EV_FERR] !== 0) begin
      n_errors++;
      $display("FAIL glitch_strobes: got %0d rx strobes want 0", ev_n[EV_SAMP] + ev_n[EV_CAP] + ev_n[EV_FERR]);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int t2;
    logic [7:0] got;
    clear_ev();
    t = cyc;
    tx_valid = 1'b1;
    rx_line  = 1'b0;
    next_cycle();
    tx_valid = 1'b0;
    wait_cyc(t + 15);
    n_checks++;
    if (ev_n[EV_SHIFT] !== 3 || rx_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_pre_reset: shifts=%0d rx_busy=%b want 3 1", ev_n[EV_SHIFT], rx_busy);
    end
    #1 rst_n = 1'b0;
    #1;
    got = {tx_ready, load_en, shift_en, tx_done, sample_en, cap_en, frame_err, rx_busy};
    n_checks++;
    if (got !== 8'b1000_0000) begin
      n_errors++;
      $display("FAIL mid_reset_outputs: got %b want 10000000", got);
    end
    clear_ev();
    rx_line = 1'b1;
    repeat (3) next_cycle();
    rst_n    = 1'b1;
    tx_valid = 1'b1;
    t2 = cyc;
    next_cycle();
    tx_valid = 1'b0;
    wait_cyc(t2 + 45);
    n_checks++;
    if (seq_ok(EV_LOAD, t2 + 1, 0, 1) !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_load: %0d pulses first@%0d, want 1 at %0d", ev_n[EV_LOAD], ev_t[EV_LOAD][0], t2 + 1);
    end
    n_checks++;
    if (seq_ok(EV_SHIFT, t2 + 5, CPB, 8) !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_shift: %0d pulses first@%0d, want 8 from %0d", ev_n[EV_SHIFT], ev_t[EV_SHIFT][0], t2 + 5);
    end
    n_checks++;
    if (seq_ok(EV_DONE, t2 + 33, 0, 1) !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_done: %0d pulses first@%0d, want 1 at %0d", ev_n[EV_DONE], ev_t[EV_DONE][0], t2 + 33);
    end
    n_checks++;
    if (ev_n[EV_SAMP] + ev_n[EV_CAP] + ev_n[EV_FERR] !== 0) begin
      n_errors++;
      $display("FAIL mid_rx_quiet: got %0d rx strobes want 0", ev_n[EV_SAMP] + ev_n[EV_CAP] + ev_n[EV_FERR]);
    end
  endtask

  task automatic test_concurrent();
    int t;
    clear_ev();
    t = cyc;
    fork
      begin
        tx_valid = 1'b1;
        next_cycle();
        tx_valid = 1'b0;
      end
      begin
        repeat (3) next_cycle();
        send_frame(8'h3C, 1'b1);
      end
    join
    wait_cyc(t + 55);
    n_checks++;
    if (seq_ok(EV_SHIFT, t + 5, CPB, 8) !== 1'b1 || seq_ok(EV_DONE, t + 33, 0, 1) !== 1'b1) begin
      n_errors++;
      $display("FAIL conc_tx: shifts=%0d first@%0d done@%0d, want 8 from %0d done@%0d", ev_n[EV_SHIFT], ev_t[EV_SHIFT][0], ev_t[EV_DONE][0], t + 5, t + 33);
    end
    n_checks++;
    if (seq_ok(EV_SAMP, t + 3 + 8, CPB, 8) !== 1'b1) begin
      n_errors++;
      $display("FAIL conc_rx_sample: %0d pulses first@%0d, want 8 from %0d", ev_n[EV_SAMP], ev_t[EV_SAMP][0], t + 11);
    end
    n_checks++;
    if (seq_ok(EV_CAP, t + 3 + 40, 0, 1) !== 1'b1 || ev_n[EV_FERR] !== 0) begin
      n_errors++;
      $display("FAIL conc_rx_cap: cap=%0d@%0d ferr=%0d, want 1@%0d 0", ev_n[EV_CAP], ev_t[EV_CAP][0], ev_n[EV_FERR], t + 43);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    clear_ev();
    t = cyc;
    tx_valid = 1'b1;
    wait_cyc(t + 35);
    tx_valid = 1'b0;
    wait_cyc(t + 75);
    n_checks++;
    if (seq_ok(EV_LOAD, t + 1, 34, 2) !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_load: %0d pulses first@%0d, want 2 at %0d,%0d", ev_n[EV_LOAD], ev_t[EV_LOAD][0], t + 1, t + 35);
    end
    n_checks++;
    if (seq_ok(EV_DONE, t + 33, 34, 2) !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_done: %0d pulses first@%0d, want 2 at %0d,%0d", ev_n[EV_DONE], ev_t[EV_DONE][0], t + 33, t + 67);
    end
    n_checks++;
    if (ev_n[EV_SHIFT] !== 16 || ev_t[EV_SHIFT][8] !== t + 39 || ev_t[EV_SHIFT][15] !== t + 67) begin
      n_errors++;
      $display("FAIL b2b_shift: %0d pulses [8]@%0d [15]@%0d, want 16 %0d %0d", ev_n[EV_SHIFT], ev_t[EV_SHIFT][8], ev_t[EV_SHIFT][15], t + 39, t + 67);
    end
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (n_overlap !== 0) begin
      n_errors++;
      $display("FAIL exclusive_strobes: got %0d overlapping cycles want 0", n_overlap);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_ev();
    test_reset();
    test_tx_single();
    test_rx_frame(1'b1);
    test_rx_frame(1'b0);
    repeat (10) next_cycle();
    test_glitch();
    test_reset_mid();
    test_concurrent();
    test_back_to_back();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
